tdm_demux_4ch: RTL and testbench

//  Receive-side demultiplexer for the time-division channel bus.
//  - A serial stream of WIDTH-bit samples arrives one per valid beat; frame_sync marks the slot-0 sample.
//  - Each sample is routed to its channel register; a per-channel strobe pulses on update.
//  - Frame alignment is tracked by a HUNT/LOCKED state machine with sync-error reporting.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_ctr.sv | 33 +++
 rtl/tdm_demux_4ch.sv | 131 +++++++++++++
 tb/tb_tdm_demux_4ch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the time-division channel bus (receive demux and transmit mux).
package tdm_pkg;

    localparam int unsigned TDM_WIDTH = 8;
    localparam int unsigned TDM_NCH   = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-NCH slot counter for the TDM demux.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active-high (slot -> 0)
//   load  - force slot to 1 (the slot following a sync sample); wins over en
//   en    - advance slot by one, wrapping NCH-1 -> 0
//   slot  - current slot index
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = TDM_NCH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     en,
    output logic [$clog2(NCH)-1:0]   slot
);

    localparam int unsigned SW = $clog2(NCH);

    // NCH is a power of two, so the natural SW-bit overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (load) begin
            slot <= SW'(1);
        end else if (en) begin
            slot <= slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Receive-side TDM demultiplexer: routes each valid sample to its channel
// register and tracks frame alignment with a HUNT/LOCKED state machine.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   din         - sample for the current slot
//   din_valid   - din/frame_sync qualified this cycle
//   frame_sync  - with din_valid: this sample is slot 0
//   dout        - channel registers, ch k = dout[k*WIDTH +: WIDTH]
//   dout_valid  - one-cycle pulse, bit k = ch k updated
//   frame_done  - one-cycle pulse when slot NCH-1 is written
//   locked      - high while aligned to the frame
//   sync_err    - one-cycle pulse on a framing violation
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = TDM_WIDTH,
    parameter int unsigned NCH   = TDM_NCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]       dout_valid,
    output logic                 frame_done,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int unsigned SW = $clog2(NCH);

    tdm_state_t               state_q;
    tdm_state_t               state_d;
    logic [SW-1:0]            slot;
    logic                     load_c;
    logic                     inc_c;
    logic                     wr_c;
    logic [SW-1:0]            wr_idx_c;
    logic                     frame_done_c;
    logic                     sync_err_c;
    logic [NCH-1:0][WIDTH-1:0] ch_q;

    tdm_slot_ctr #(
        .NCH (NCH)
    ) u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .en   (inc_c),
        .slot (slot)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-beat decisions.
    always_comb begin
        state_d      = state_q;
        load_c       = 1'b0;
        inc_c        = 1'b0;
        wr_c         = 1'b0;
        wr_idx_c     = '0;
        frame_done_c = 1'b0;
        sync_err_c   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    wr_c    = 1'b1;
                    load_c  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    if (slot == '0) begin
                        if (frame_sync) begin
                            wr_c   = 1'b1;
                            load_c = 1'b1;
                        end else begin
                            // Missing sync: drop the sample and re-acquire.
                            sync_err_c = 1'b1;
                            state_d    = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: realign on this sample, truncated frame never completes.
                        sync_err_c = 1'b1;
                        wr_c       = 1'b1;
                        load_c     = 1'b1;
                    end else begin
                        wr_c         = 1'b1;
                        wr_idx_c     = slot;
                        inc_c        = 1'b1;
                        frame_done_c = (slot == SW'(NCH - 1));
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Channel registers and one-cycle output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q       <= '0;
            dout_valid <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            dout_valid <= '0;
            if (wr_c) begin
                ch_q[wr_idx_c] <= din;
                dout_valid     <= NCH'(1) << wr_idx_c;
            end
            frame_done <= frame_done_c;
            sync_err   <= sync_err_c;
            locked     <= (state_d == LOCKED);
        end
    end

    assign dout = ch_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch with a scoreboard of expected outputs.
module tb_tdm_demux_4ch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic        frame_done;
    logic        locked;
    logic        sync_err;

    tdm_demux_4ch #(.WIDTH(8), .NCH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dout;
        logic [3:0]  dv;
        logic        fd;
        logic        se;
        logic        lk;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state.
    bit         m_locked;
    int         m_slot;
    logic [7:0] m_ch [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_slot   = 0;
        for (int k = 0; k < 4; k++) m_ch[k] = '0;
    endtask

    function automatic logic [31:0] model_dout();
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = m_ch[k];
        return r;
    endfunction

    // Predict the outputs visible after the next clock edge.
    task automatic model_step(input logic v, input logic s, input logic [7:0] d, output exp_t e);
        e.dv = '0; e.fd = 1'b0; e.se = 1'b0;
        if (rst) begin
            model_reset();
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0] = d; e.dv = 4'b0001; m_slot = 1; m_locked = 1'b1;
                end
            end else if (m_slot == 0) begin
                if (s) begin
                    m_ch[0] = d; e.dv = 4'b0001; m_slot = 1;
                end else begin
                    e.se = 1'b1; m_locked = 1'b0;
                end
            end else if (s) begin
                e.se = 1'b1; m_ch[0] = d; e.dv = 4'b0001; m_slot = 1;
            end else begin
                m_ch[m_slot] = d;
                e.dv = 4'(1 << m_slot);
                e.fd = (m_slot == 3);
                m_slot = (m_slot + 1) % 4;
            end
        end
        e.dout = model_dout();
        e.lk   = m_locked;
    endtask

    task automatic cycle(input logic v, input logic s, input logic [7:0] d, input string tag);
        exp_t e;
        din_valid  = v;
        frame_sync = s;
        din        = d;
        model_step(v, s, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_dout"},   64'(dout),       64'(e.dout));
            check({tag, "_dv"},     64'(dout_valid), 64'(e.dv));
            check({tag, "_fd"},     64'(frame_done), 64'(e.fd));
            check({tag, "_se"},     64'(sync_err),   64'(e.se));
            check({tag, "_locked"}, 64'(locked),     64'(e.lk));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, tag);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ch2_before;
        model_reset();
        #1;
        check("rst_dout", 64'(dout), 64'h0);
        check("rst_locked", 64'(locked), 64'h0);
        idle(2, "rst");
        rst = 1'b0;
        idle(1, "rel");

        // Test 1: a clean frame.
        cycle(1, 1, 8'hA0, "t1b0");
        check("t1_dv0", 64'(dout_valid), 64'h1);
        check("t1_lock", 64'(locked), 64'h1);
        cycle(1, 0, 8'hA1, "t1b1");
        cycle(1, 0, 8'hA2, "t1b2");
        cycle(1, 0, 8'hA3, "t1b3");
        check("t1_dv3", 64'(dout_valid), 64'h8);
        check("t1_fd", 64'(frame_done), 64'h1);
        check("t1_dout", 64'(dout), 64'hA3A2A1A0);
        idle(1, "t1i");

        // Test 2: hunting discards unsynced samples.
        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        cycle(1, 0, 8'h11, "t2a");
        cycle(1, 0, 8'h22, "t2b");
        check("t2_nodv", 64'(dout_valid), 64'h0);
        cycle(1, 1, 8'h33, "t2c");
        check("t2_ch0", 64'(dout[7:0]), 64'h33);
        check("t2_lock", 64'(locked), 64'h1);

        // Test 3: early sync on slot 2.
        cycle(1, 0, 8'h34, "t3a");
        ch2_before = dout[23:16];
        cycle(1, 1, 8'h55, "t3b");
        check("t3_se", 64'(sync_err), 64'h1);
        check("t3_ch0", 64'(dout[7:0]), 64'h55);
        check("t3_ch2", 64'(dout[23:16]), 64'(ch2_before));
        check("t3_fd", 64'(frame_done), 64'h0);
        cycle(1, 0, 8'h66, "t3c");
        check("t3_ch1", 64'(dout[15:8]), 64'h66);
        check("t3_dv1", 64'(dout_valid), 64'h2);

        // Test 4: missing sync at slot 0.
        cycle(1, 0, 8'h67, "t4a");
        cycle(1, 0, 8'h68, "t4b");
        cycle(1, 0, 8'h77, "t4c");
        check("t4_se", 64'(sync_err), 64'h1);
        check("t4_unlock", 64'(locked), 64'h0);
        check("t4_dout", 64'(dout), 64'h68676655);
        cycle(1, 1, 8'h88, "t4d");
        check("t4_ch0", 64'(dout[7:0]), 64'h88);
        check("t4_relock", 64'(locked), 64'h1);
        cycle(1, 0, 8'h89, "t4e");
        cycle(1, 0, 8'h8A, "t4f");
        cycle(1, 0, 8'h8B, "t4g");

        // Test 5: valid gaps, beats on cycles 0, 3, 4, 9.
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      cycle(1, 1, 8'hB0, "t5");
            else if (i == 3) cycle(1, 0, 8'hB1, "t5");
            else if (i == 4) cycle(1, 0, 8'hB2, "t5");
            else if (i == 9) cycle(1, 0, 8'hB3, "t5");
            else             cycle(0, 0, 8'hFF, "t5");
        end
        check("t5_fd", 64'(frame_done), 64'h1);
        check("t5_dout", 64'(dout), 64'hB3B2B1B0);
        idle(1, "t5i");
        check("t5_fd_off", 64'(frame_done), 64'h0);

        // Test 6: asynchronous reset mid-frame.
        cycle(1, 1, 8'hC0, "t6a");
        cycle(1, 0, 8'hC1, "t6b");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_dout", 64'(dout), 64'h0);
        check("t6_async_dv", 64'(dout_valid), 64'h0);
        check("t6_async_lock", 64'(locked), 64'h0);
        cycle(1, 1, 8'hD0, "t6c");
        rst = 1'b0;
        cycle(1, 0, 8'hE1, "t6d");
        check("t6_nowrite", 64'(dout), 64'h0);
        cycle(1, 1, 8'hE0, "t6e");
        check("t6_ch0", 64'(dout[7:0]), 64'hE0);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            cycle(v, s, 8'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
